vga_timing_gen: RTL

//  Parametrised VGA/VESA raster timing generator: next generation of the fixed 640x480 sync block.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/VESA raster timing generator with pixel clock-enable
//
// Purpose: derives a pixel clock-enable from clk and walks an H_TOTAL x V_TOTAL raster,
// producing programmable-polarity syncs, active-video flag, coordinates, line/frame
// strobes and a frame counter. No divided clock is produced.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   en           timing enable; low freezes divider and raster
//   pix_ce       1-clk pulse; raster advances on the clk edge ending this cycle
//   h_sync       horizontal sync, asserted level H_POL
//   v_sync       vertical sync, asserted level V_POL
//   video_on     high inside the active region
//   pixel_x      horizontal count 0..H_TOTAL-1
//   pixel_y      vertical count 0..V_TOTAL-1
//   line_start   1-clk strobe when pixel_x becomes 0
//   frame_start  1-clk strobe when (pixel_x,pixel_y) becomes (0,0)
//   frame_count  frames started since reset, wraps modulo 2^FW
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIDEO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIDEO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int CW      = 12,
  parameter int FW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] L_DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] L_H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] L_V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] L_H_VID   = CW'(H_VIDEO);
  localparam logic [CW-1:0] L_V_VID   = CW'(V_VIDEO);
  localparam logic [CW-1:0] L_HS_BEG  = CW'(H_VIDEO + H_FP);
  localparam logic [CW-1:0] L_HS_END  = CW'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [CW-1:0] L_VS_BEG  = CW'(V_VIDEO + V_FP);
  localparam logic [CW-1:0] L_VS_END  = CW'(V_VIDEO + V_FP + V_SYNC);
  localparam logic          L_H_ACT   = (H_POL != 0);
  localparam logic          L_V_ACT   = (V_POL != 0);

  generate
    if (CLK_DIV < 1 || H_BP < 1 || V_BP < 1 ||
        (H_TOTAL - 1) >= (2 ** CW) || (V_TOTAL - 1) >= (2 ** CW)) begin : g_bad_params
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic          r_hs;
  logic          r_vs;
  logic          r_vid;
  logic          r_ls;
  logic          r_fs;
  logic [FW-1:0] r_fc;

  logic          w_div_last;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [CW-1:0] w_h_nxt;
  logic [CW-1:0] w_v_nxt;

  always_comb begin
    w_div_last = (r_div == L_DIV_MAX);
    w_h_wrap   = (r_h == L_H_MAX);
    w_v_wrap   = (r_v == L_V_MAX);
    w_h_nxt    = w_h_wrap ? '0 : r_h + 1'b1;
    w_v_nxt    = r_v;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? '0 : r_v + 1'b1;
    end
  end

  // Gated by rst so the enable stays low during the reset cycle even when CLK_DIV=1.
  assign pix_ce = rst && en && w_div_last;

  // Every output is registered from the next-state counts so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
      r_h   <= L_H_MAX;
      r_v   <= L_V_MAX;
      r_hs  <= ~L_H_ACT;
      r_vs  <= ~L_V_ACT;
      r_vid <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
      r_fc  <= '0;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (en) begin
        r_div <= w_div_last ? '0 : r_div + 1'b1;
      end
      if (pix_ce) begin
        r_h   <= w_h_nxt;
        r_v   <= w_v_nxt;
        r_hs  <= (w_h_nxt >= L_HS_BEG && w_h_nxt < L_HS_END) ? L_H_ACT : ~L_H_ACT;
        r_vs  <= (w_v_nxt >= L_VS_BEG && w_v_nxt < L_VS_END) ? L_V_ACT : ~L_V_ACT;
        r_vid <= (w_h_nxt < L_H_VID) && (w_v_nxt < L_V_VID);
        r_ls  <= w_h_wrap;
        r_fs  <= w_h_wrap && w_v_wrap;
        if (w_h_wrap && w_v_wrap) begin
          r_fc <= r_fc + 1'b1;
        end
      end
    end
  end

  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign video_on    = r_vid;
  assign pixel_x     = r_h;
  assign pixel_y     = r_v;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_count = r_fc;

endmodule
